pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Parametrised hazard and stage-sequencing controller for the pipelined successor of the single-cycle core.
- Tracks valid/destination state per pipeline stage (IF, ID, EX, MEM, ..., WB) and drives the PC write enable and per-stage register enables.
- Inserts bubbles on load-use hazards, flushes on taken branches, freezes on memory wait, and produces EX-operand forwarding selects.
- Sits between the control unit / register file and the stage registers of the pipelined datapath.

Parameters:
- N_STAGES, 5, total stages; index 0=IF, 1=ID, 2=EX, 3=MEM, N_STAGES-1=WB; legal range 5..8
- REG_AW, 5, register address width
- SEL_W, 3, forwarding-select width; must satisfy 2^SEL_W >= N_STAGES
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous active-low reset
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_reg_write  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_dest  in  REG_AW  ID destination register
- branch_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready; freeze the pipeline
- PCWrite  out  1  PC load enable
- stage_en  out  N_STAGES  stage register enables (bit k loads stage k)
- stage_valid  out  N_STAGES  stage holds a real instruction
- bubble_ex  out  1  EX stage register loads a NOP this cycle
- fwd_a  out  SEL_W  EX operand A source: 0=regfile, k=stage k result
- fwd_b  out  SEL_W  same, for operand B
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: every register updates only on the CLK rising edge while Reset=0.
- Under reset: all valid bits 0, all tracker fields 0, stall_cnt=0. PCWrite=0 and stage_en=0 while Reset=0.
- Trackers, stage k>=2: valid, dest, reg_write, mem_read, rs, rt. Stage 2 captures the id_* inputs on advance. Stage k>=3 captures stage k-1 on advance.
- Tracker updates follow stage_en and bubble exactly, in lockstep with the datapath.
- load_use = valid[1] & valid[2] & mem_read[2] & dest[2]!=0 & ((id_use_rs & id_rs==dest[2]) | (id_use_rt & id_rt==dest[2])).
- Priority of conditions: freeze > branch > load_use > normal.
- freeze (mem_busy=1):
  - PCWrite=0, stage_en=0, bubble_ex=0; nothing moves.
  - branch_taken is ignored that cycle; it is re-evaluated once unfrozen.
  - stall_cnt increments.
- branch (branch_taken=1 and valid[2]=1):
  - PCWrite=1, all stage_en=1, bubble_ex=1.
  - Next cycle valid[1]=0 and valid[2]=0; stages >=3 advance normally.
  - load_use in the same cycle is discarded.
  - branch_taken with valid[2]=0 is ignored.
- load_use:
  - PCWrite=0, stage_en[0]=stage_en[1]=0 (IF/ID hold), stage_en[k>=2]=1, bubble_ex=1.
  - Next cycle valid[2]=0; stall_cnt increments.
- normal: PCWrite=1, all stage_en=1, valid[0] set to 1, valid[k] takes valid[k-1].
- First cycle after reset release: PCWrite=1, valid becomes 00001.
- Forwarding (combinational from trackers):
  - fwd_a = smallest k in 3..N_STAGES-1 with valid[k] & reg_write[k] & dest[k]!=0 & dest[k]==rs[2].
  - Stage 3 is skipped if mem_read[3]=1, because load data is not ready.
  - 0 if no match. fwd_b is computed the same way against rt[2].
  - Both are 0 when valid[2]=0.
- stall_cnt saturates at 2^CNT_W-1; it does not wrap.
- Register 0 never causes a hazard or a forward.
- Reset asserted mid-stall or mid-freeze: all state clears on that edge; there is no pending state.

Test Plan:
- Reset held 3 cycles, then released with no hazards -> PCWrite=0 and stage_en=0 during reset; then PCWrite=1, stage_valid=00001, 00011, 00111, 01111, 11111 on successive cycles.
- Load to r5 followed directly by an instruction reading r5 -> one cycle with PCWrite=0, stage_en=11100, bubble_ex=1, stall_cnt=1; next cycle EX has rs=5, fwd_a=4.
- Add to r3 followed by sub reading r3 as rt -> no stall; fwd_b=3 at EX. With one independent instruction between them -> fwd_b=4.
- branch_taken with valid[2]=1 while a load_use condition is also present -> PCWrite=1, bubble_ex=1, stage_valid[2:1]=00 next cycle, stall_cnt unchanged.
- mem_busy held 4 cycles with a branch pending -> all enables 0 and stall_cnt +4; the flush happens on the first unfrozen cycle.
- CNT_W=2 with 5 load-use stalls -> stall_cnt reaches 3 and holds. Reset pulsed during a freeze -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and stage-sequencing controller for the pipelined core: load-use stalls,
// taken-branch flushes, memory-wait freezes and EX operand forwarding selects.
module pipeline_ctrl #(
    parameter int unsigned N_STAGES = 5,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic [REG_AW-1:0]   id_dest,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic                PCWrite,
    output logic [N_STAGES-1:0] stage_en,
    output logic [N_STAGES-1:0] stage_valid,
    output logic                bubble_ex,
    output logic [SEL_W-1:0]    fwd_a,
    output logic [SEL_W-1:0]    fwd_b,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_LOAD_USE,
        MODE_BRANCH,
        MODE_FREEZE
    } mode_e;

    logic [N_STAGES-1:0] valid_q;
    logic [REG_AW-1:0]   dest_q [2:N_STAGES-1];
    logic                rw_q   [2:N_STAGES-1];
    logic                mr_q   [2:N_STAGES-1];
    logic [REG_AW-1:0]   ex_rs_q;
    logic [REG_AW-1:0]   ex_rt_q;
    logic                load_use;
    mode_e               mode;

    assign stage_valid = valid_q;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = valid_q[1] & valid_q[2] & mr_q[2] & (dest_q[2] != '0) &
                   ((id_use_rs & (id_rs == dest_q[2])) | (id_use_rt & (id_rt == dest_q[2])));
    end

    // Cycle mode, highest priority first
    always_comb begin
        mode = MODE_NORMAL;
        if (mem_busy) begin
            mode = MODE_FREEZE;
        end else if (branch_taken && valid_q[2]) begin
            mode = MODE_BRANCH;
        end else if (load_use) begin
            mode = MODE_LOAD_USE;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        stage_en  = '0;
        bubble_ex = 1'b0;
        if (Reset) begin
            case (mode)
                MODE_NORMAL: begin
                    PCWrite  = 1'b1;
                    stage_en = '1;
                end
                MODE_BRANCH: begin
                    PCWrite   = 1'b1;
                    stage_en  = '1;
                    bubble_ex = 1'b1;
                end
                MODE_LOAD_USE: begin
                    stage_en  = {{(N_STAGES-2){1'b1}}, 2'b00};
                    bubble_ex = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Trackers move in lockstep with the datapath stage registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            valid_q   <= '0;
            stall_cnt <= '0;
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
            for (int k = 2; k < int'(N_STAGES); k++) begin
                dest_q[k] <= '0;
                rw_q[k]   <= 1'b0;
                mr_q[k]   <= 1'b0;
            end
        end else begin
            if ((mode == MODE_FREEZE || mode == MODE_LOAD_USE) && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (stage_en[0]) begin
                valid_q[0] <= 1'b1;
            end
            if (stage_en[1]) begin
                valid_q[1] <= valid_q[0] & (mode != MODE_BRANCH);
            end
            if (stage_en[2]) begin
                if (bubble_ex) begin
                    valid_q[2] <= 1'b0;
                    dest_q[2]  <= '0;
                    rw_q[2]    <= 1'b0;
                    mr_q[2]    <= 1'b0;
                    ex_rs_q    <= '0;
                    ex_rt_q    <= '0;
                end else begin
                    valid_q[2] <= valid_q[1];
                    dest_q[2]  <= id_dest;
                    rw_q[2]    <= id_reg_write;
                    mr_q[2]    <= id_mem_read;
                    ex_rs_q    <= id_rs;
                    ex_rt_q    <= id_rt;
                end
            end
            for (int k = 3; k < int'(N_STAGES); k++) begin
                if (stage_en[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    dest_q[k]  <= dest_q[k-1];
                    rw_q[k]    <= rw_q[k-1];
                    mr_q[k]    <= mr_q[k-1];
                end
            end
        end
    end

    // Youngest producer wins; a load still in MEM has no data to forward
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = int'(N_STAGES) - 1; k >= 3; k--) begin
            if (valid_q[k] && rw_q[k] && dest_q[k] != '0 && !(k == 3 && mr_q[k])) begin
                if (dest_q[k] == ex_rs_q) fwd_a = SEL_W'(k);
                if (dest_q[k] == ex_rt_q) fwd_b = SEL_W'(k);
            end
        end
        if (!valid_q[2]) begin
            fwd_a = '0;
            fwd_b = '0;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expectations,
// a monitor on the falling edge pops and compares them.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic       mr;
        logic [4:0] dst;
    } ins_t;

    typedef struct packed {
        logic [6:0]  mask;
        logic        pcw;
        logic [4:0]  en;
        logic [4:0]  vld;
        logic        bub;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    // mask bits: 0 PCWrite, 1 stage_en, 2 stage_valid, 3 bubble_ex, 4 fwd_a, 5 fwd_b, 6 stall_cnt
    localparam logic [6:0] M_ALL = 7'h7F;
    localparam logic [6:0] M_NV  = 7'h6B;
    localparam logic [6:0] M_NVA = 7'h6B & 7'h6F;
    localparam logic [6:0] M_CTL = 7'h4B;

    logic        CLK;
    logic        Reset;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read;
    logic        branch_taken, mem_busy;
    logic        PCWrite, bubble_ex;
    logic [4:0]  stage_en, stage_valid;
    logic [2:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        pcw2, bub2;
    logic [4:0]  en2, vld2;
    logic [2:0]  fa2, fb2;
    logic [1:0]  cnt2;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_n   = 0;

    pipeline_ctrl dut (
        .CLK(CLK), .Reset(Reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PCWrite(PCWrite), .stage_en(stage_en), .stage_valid(stage_valid),
        .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PCWrite(pcw2), .stage_en(en2), .stage_valid(vld2),
        .bubble_ex(bub2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ins_t ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic rw, input logic mr, input logic [4:0] dst);
        ins_t i;
        i = '{rs: rs, rt: rt, urs: urs, urt: urt, rw: rw, mr: mr, dst: dst};
        return i;
    endfunction

    function automatic exp_t ex(input logic [6:0] m, input logic pcw, input logic [4:0] en,
                                input logic [4:0] vld, input logic bub, input logic [2:0] fa,
                                input logic [2:0] fb, input logic [15:0] cnt);
        exp_t e;
        e = '{mask: m, pcw: pcw, en: en, vld: vld, bub: bub, fa: fa, fb: fb, cnt: cnt};
        return e;
    endfunction

    task automatic drive(input ins_t i, input logic rst, input logic br, input logic busy, input exp_t e);
        @(posedge CLK);
        #1;
        Reset = rst;
        {id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_dest} = i;
        branch_taken = br;
        mem_busy     = busy;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, req);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc_n++;
                if (e.mask[0]) begin
                    chk("PCWrite", 16'(PCWrite), 16'(e.pcw));
                    chk("u2_PCWrite", 16'(pcw2), 16'(e.pcw));
                end
                if (e.mask[1]) begin
                    chk("stage_en", 16'(stage_en), 16'(e.en));
                    chk("u2_stage_en", 16'(en2), 16'(e.en));
                end
                if (e.mask[2]) begin
                    chk("stage_valid", 16'(stage_valid), 16'(e.vld));
                    chk("u2_stage_valid", 16'(vld2), 16'(e.vld));
                end
                if (e.mask[3]) begin
                    chk("bubble_ex", 16'(bubble_ex), 16'(e.bub));
                    chk("u2_bubble_ex", 16'(bub2), 16'(e.bub));
                end
                if (e.mask[4]) begin
                    chk("fwd_a", 16'(fwd_a), 16'(e.fa));
                    chk("u2_fwd_a", 16'(fa2), 16'(e.fa));
                end
                if (e.mask[5]) begin
                    chk("fwd_b", 16'(fwd_b), 16'(e.fb));
                    chk("u2_fwd_b", 16'(fb2), 16'(e.fb));
                end
                if (e.mask[6]) begin
                    chk("stall_cnt", stall_cnt, e.cnt);
                    chk("stall_cnt_sat2", 16'(cnt2), (e.cnt > 16'd3) ? 16'd3 : e.cnt);
                end
            end
        end
    end

    initial begin
        ins_t nop, lw5, add6, add3, sub7, or8, sub9, add5, x10, sub11, lw0, add12;
        Reset = 1'b0;
        {id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_dest} = '0;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;

        nop   = '0;
        lw5   = ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        add6  = ins(5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        add3  = ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        sub7  = ins(5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        or8   = ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        sub9  = ins(5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
        add5  = ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        x10   = ins(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10);
        sub11 = ins(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11);
        lw0   = ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        add12 = ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12);

        // reset held, then pipeline fill
        repeat (3) drive(nop, 1'b0, 1'b0, 1'b0, ex(M_ALL, 1'b0, 5'h00, 5'h00, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h00, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h01, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h03, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h07, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h0F, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd0));
        // load r5 then consumer of r5: one stall, then forward from WB
        drive(lw5,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(add6, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b0, 5'h1C, 5'h1F, 1'b1, 3'd0, 3'd0, 16'd0));
        drive(add6, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1B, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(add3, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h17, 1'b0, 3'd4, 3'd0, 16'd1));
        // ALU producer then rt consumer: adjacent -> 3, one apart -> 4
        drive(sub7, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h0F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(add3, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd3, 16'd1));
        drive(or8,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(sub9, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(nop,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd4, 16'd1));
        // load sitting in MEM is skipped in favour of older ALU result in WB
        drive(add5, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(lw5,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(x10,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(nop,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd4, 3'd0, 16'd1));
        // two producers of r3: the younger (stage 3) wins
        drive(add3,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(add3,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(sub11, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(nop,   1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd3, 3'd3, 16'd1));
        // load to r0 never stalls
        drive(lw0,   1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(add12, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(nop,   1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        // branch beats load_use; branch with EX empty is ignored
        drive(lw5,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(add6, 1'b1, 1'b1, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h1F, 1'b1, 3'd0, 3'd0, 16'd1));
        drive(nop,  1'b1, 1'b1, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h19, 1'b0, 3'd0, 3'd0, 16'd1));
        drive(nop,  1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h13, 1'b0, 3'd0, 3'd0, 16'd1));
        // four frozen cycles with a branch pending, flush on first free cycle
        for (int k = 0; k < 4; k++)
            drive(nop, 1'b1, 1'b1, 1'b1, ex(M_ALL, 1'b0, 5'h00, 5'h07, 1'b0, 3'd0, 3'd0, 16'(1 + k)));
        drive(nop, 1'b1, 1'b1, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h07, 1'b1, 3'd0, 3'd0, 16'd5));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h09, 1'b0, 3'd0, 3'd0, 16'd5));
        // five more load-use stalls; the 2-bit counter stays at 3
        for (int i = 0; i < 5; i++) begin
            drive(lw5,  1'b1, 1'b0, 1'b0, ex(M_NVA, 1'b1, 5'h1F, 5'h00, 1'b0, 3'd0, 3'd0, 16'(5 + i)));
            drive(add6, 1'b1, 1'b0, 1'b0, ex(M_NV,  1'b0, 5'h1C, 5'h00, 1'b1, 3'd0, 3'd0, 16'(5 + i)));
            drive(add6, 1'b1, 1'b0, 1'b0, ex(M_NV,  1'b1, 5'h1F, 5'h00, 1'b0, 3'd0, 3'd0, 16'(6 + i)));
        end
        // reset pulsed during a freeze
        drive(nop, 1'b1, 1'b0, 1'b1, ex(M_CTL, 1'b0, 5'h00, 5'h00, 1'b0, 3'd0, 3'd0, 16'd10));
        drive(nop, 1'b1, 1'b0, 1'b1, ex(M_CTL, 1'b0, 5'h00, 5'h00, 1'b0, 3'd0, 3'd0, 16'd11));
        drive(nop, 1'b0, 1'b0, 1'b1, ex(M_CTL, 1'b0, 5'h00, 5'h00, 1'b0, 3'd0, 3'd0, 16'd12));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h00, 1'b0, 3'd0, 3'd0, 16'd0));
        drive(nop, 1'b1, 1'b0, 1'b0, ex(M_ALL, 1'b1, 5'h1F, 5'h01, 1'b0, 3'd0, 3'd0, 16'd0));

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge CLK);
        @(posedge CLK);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
